acc_ctrl_gen2: RTL

Parametrised second-generation control unit for the accumulator datapath: sequences fetch/decode/execute, drives register-load, memory and ALU strobes, and exposes a one-hot state vector. Over the first-generation controller it adds an opcode bus of configurable width, variable-latency memory with a ready handshake and timeout, an overflow trap, HALT/LOAD/CLRAC/NOP instructions, and an error code. Sits between the instruction register/status flags and the datapath strobes.

---
 rtl/acc_ctrl_pkg.sv | 50 +++++
 rtl/mem_wait_timer.sv | 47 ++++
 rtl/acc_ctrl_gen2.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : acc_ctrl_pkg
// Purpose : Shared definitions for the accumulator controller. Holds the
//           one-hot state encoding and its bit indices, the opcode values
//           (NOP..HALT) and the error codes reported on ERR_CODE.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package acc_ctrl_pkg;

    // Bit positions of each state inside the one-hot STATE vector
    localparam int c_idx_rst    = 0;
    localparam int c_idx_fetch  = 1;
    localparam int c_idx_decode = 2;
    localparam int c_idx_exalu  = 3;
    localparam int c_idx_exst   = 4;
    localparam int c_idx_exbnz  = 5;
    localparam int c_idx_exmisc = 6;
    localparam int c_idx_halt   = 7;
    localparam int c_idx_traps  = 8;

    typedef enum logic [8:0] {
        ST_RST    = 9'(1) << c_idx_rst,
        ST_FETCH  = 9'(1) << c_idx_fetch,
        ST_DECODE = 9'(1) << c_idx_decode,
        ST_EXALU  = 9'(1) << c_idx_exalu,
        ST_EXST   = 9'(1) << c_idx_exst,
        ST_EXBNZ  = 9'(1) << c_idx_exbnz,
        ST_EXMISC = 9'(1) << c_idx_exmisc,
        ST_HALT   = 9'(1) << c_idx_halt,
        ST_TRAPS  = 9'(1) << c_idx_traps
    } state_t;

    localparam logic [2:0] c_op_nop   = 3'd0;
    localparam logic [2:0] c_op_add   = 3'd1;
    localparam logic [2:0] c_op_sub   = 3'd2;
    localparam logic [2:0] c_op_store = 3'd3;
    localparam logic [2:0] c_op_bnz   = 3'd4;
    localparam logic [2:0] c_op_load  = 3'd5;
    localparam logic [2:0] c_op_clrac = 3'd6;
    localparam logic [2:0] c_op_halt  = 3'd7;

    localparam logic [1:0] c_err_none        = 2'b00;
    localparam logic [1:0] c_err_mem_timeout = 2'b01;
    localparam logic [1:0] c_err_overflow    = 2'b10;
    localparam logic [1:0] c_err_illegal     = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_timer
// Purpose : Counts cycles spent waiting on memory and flags when the count
//           reaches MEM_TIMEOUT. Saturates at MEM_TIMEOUT. With
//           MEM_TIMEOUT = 0 the timer is removed and expired is tied low.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-high reset
//           clear   - synchronous clear of the count
//           enable  - count one wait cycle
//           expired - count has reached MEM_TIMEOUT
// Rev     : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timer
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (clear) begin
                    r_cnt <= '0;
                end else if (enable && (r_cnt != CW'(MEM_TIMEOUT))) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign expired = (r_cnt == CW'(MEM_TIMEOUT));
        end else begin : g_no_timer
            wire w_unused = &{1'b0, clk, rst, clear, enable};
            assign expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/acc_ctrl_gen2.sv
`default_nettype none
// ============================================================================
// Module  : acc_ctrl_gen2
// Purpose : Fetch/decode/execute sequencer for the accumulator datapath with
//           variable-latency memory (ready handshake + timeout), overflow
//           trap, HALT and illegal-opcode trapping.
// Ports   : CLK, RESET (async, active high), CLR (sync soft clear)
//           OPCODE [OPW], ZERO, OVERFLOW, MEM_RDY       - status inputs
//           LD_IR, LD_AC, LD_D, LD_PC, PC_CNT, CL, CL_AC - register strobes
//           MEM_EN, RORW, DORPC, ADDSUB, PASS            - memory/ALU control
//           HALTED, TRAP, ERR_CODE[2], STATE[9] (one-hot) - status
// Rev     : 1.0  initial release
// ============================================================================
module acc_ctrl_gen2
    import acc_ctrl_pkg::*;
#(
    parameter int OPW         = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int OVF_TRAP_EN = 1
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           CLR,
    input  logic [OPW-1:0] OPCODE,
    input  logic           ZERO,
    input  logic           OVERFLOW,
    input  logic           MEM_RDY,
    output logic           LD_IR,
    output logic           LD_AC,
    output logic           LD_D,
    output logic           LD_PC,
    output logic           PC_CNT,
    output logic           CL,
    output logic           CL_AC,
    output logic           MEM_EN,
    output logic           RORW,
    output logic           DORPC,
    output logic           ADDSUB,
    output logic           PASS,
    output logic           HALTED,
    output logic           TRAP,
    output logic [1:0]     ERR_CODE,
    output logic [8:0]     STATE
);

    state_t     r_state;
    logic [2:0] r_op;
    logic [1:0] r_err;
    logic       r_ld_d;

    logic       w_illegal;
    logic       w_in_mem;
    logic       w_expired;
    logic       w_tmr_clear;
    logic       w_tmr_enable;
    logic [2:0] w_op;

    assign w_op = OPCODE[2:0];

    // Only opcode bits above bit 2 can make an opcode illegal
    generate
        if (OPW > 3) begin : g_wide_op
            assign w_illegal = |OPCODE[OPW-1:3];
        end else begin : g_narrow_op
            assign w_illegal = 1'b0;
        end
    endgenerate

    assign w_in_mem = r_state[c_idx_fetch] | r_state[c_idx_exalu] | r_state[c_idx_exst];

    // A completed access always leaves the memory state, so clearing on
    // MEM_RDY guarantees a zero count on entry to the next memory state.
    assign w_tmr_clear  = ~w_in_mem | MEM_RDY | CLR;
    assign w_tmr_enable = w_in_mem & ~MEM_RDY;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (CLK),
        .rst     (RESET),
        .clear   (w_tmr_clear),
        .enable  (w_tmr_enable),
        .expired (w_expired)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_RST;
            r_op    <= c_op_nop;
            r_err   <= c_err_none;
            r_ld_d  <= 1'b0;
        end else begin
            r_ld_d <= 1'b0;
            if (CLR) begin
                r_state <= ST_RST;
                r_err   <= c_err_none;
            end else begin
                case (r_state)
                    ST_RST: begin
                        r_err   <= c_err_none;
                        r_state <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (MEM_RDY) begin
                            r_state <= ST_DECODE;
                        end else if (w_expired) begin
                            r_state <= ST_TRAPS;
                            r_err   <= c_err_mem_timeout;
                        end
                    end
                    ST_DECODE: begin
                        r_op <= w_op;
                        if (w_illegal) begin
                            r_state <= ST_TRAPS;
                            r_err   <= c_err_illegal;
                        end else begin
                            case (w_op)
                                c_op_add, c_op_sub, c_op_load: r_state <= ST_EXALU;
                                c_op_store: begin
                                    r_state <= ST_EXST;
                                    r_ld_d  <= 1'b1;   // LD_D only on first EXST cycle
                                end
                                c_op_bnz:  r_state <= ST_EXBNZ;
                                c_op_halt: r_state <= ST_HALT;
                                default:   r_state <= ST_EXMISC;   // NOP, CLRAC
                            endcase
                        end
                    end
                    ST_EXALU: begin
                        if (MEM_RDY) begin
                            if (OVERFLOW && (r_op != c_op_load) && (OVF_TRAP_EN != 0)) begin
                                r_state <= ST_TRAPS;
                                r_err   <= c_err_overflow;
                            end else begin
                                r_state <= ST_FETCH;
                            end
                        end else if (w_expired) begin
                            r_state <= ST_TRAPS;
                            r_err   <= c_err_mem_timeout;
                        end
                    end
                    ST_EXST: begin
                        if (MEM_RDY) begin
                            r_state <= ST_FETCH;
                        end else if (w_expired) begin
                            r_state <= ST_TRAPS;
                            r_err   <= c_err_mem_timeout;
                        end
                    end
                    ST_EXBNZ:  r_state <= ST_FETCH;
                    ST_EXMISC: r_state <= ST_FETCH;
                    ST_HALT:   r_state <= ST_HALT;
                    ST_TRAPS:  r_state <= ST_TRAPS;
                    default:   r_state <= ST_RST;
                endcase
            end
        end
    end

    assign STATE    = r_state;
    assign ERR_CODE = r_err;
    assign LD_D     = r_ld_d;

    assign CL       = r_state[c_idx_rst];
    assign CL_AC    = r_state[c_idx_rst] | (r_state[c_idx_exmisc] & (r_op == c_op_clrac));
    assign MEM_EN   = w_in_mem;
    assign RORW     = r_state[c_idx_fetch] | r_state[c_idx_exalu];
    assign DORPC    = r_state[c_idx_exalu] | r_state[c_idx_exst];
    assign ADDSUB   = r_state[c_idx_exalu] & (r_op == c_op_sub);
    assign PASS     = r_state[c_idx_exalu] & (r_op == c_op_load);
    assign HALTED   = r_state[c_idx_halt];
    assign TRAP     = r_state[c_idx_traps];

    // Strobes qualified by same-cycle status inputs
    assign LD_IR    = r_state[c_idx_fetch] & MEM_RDY;
    assign PC_CNT   = r_state[c_idx_fetch] & MEM_RDY;
    assign LD_AC    = r_state[c_idx_exalu] & MEM_RDY;
    assign LD_PC    = r_state[c_idx_exbnz] & ~ZERO;

endmodule
`default_nettype wire
